// File: rtl/traffic_request_gen_if.sv
// Field-side inputs and FSM-side request outputs of traffic_request_gen.
// Handshake: ped is a level request held until the FSM pulses ped_clr; ped_clr is an acknowledge only.
interface traffic_request_gen_if;
  logic [3:0] raw_car;
  logic       raw_button;
  logic       ped_clr;
  logic       car1;
  logic       car2;
  logic       car3;
  logic       car4;
  logic       ped;
  logic [3:0] stuck;

  modport master (
    output raw_car, raw_button, ped_clr,
    input  car1, car2, car3, car4, ped, stuck
  );

  modport slave (
    input  raw_car, raw_button, ped_clr,
    output car1, car2, car3, car4, ped, stuck
  );
endinterface

// File: rtl/traffic_request_gen.sv
// Synchronizes/debounces loop detectors and ped button, latches ped until ped_clr.
// Optional stuck-loop masking enabled by defining TRAFFIC_STUCK_DET_EN.
module traffic_request_gen #(
  parameter int DEBOUNCE    = 4,
  parameter int STUCK_LIMIT = 1000
) (
  input  logic                 clock,
  input  logic                 reset,
  traffic_request_gen_if.slave bus
);

  if (DEBOUNCE < 1 || DEBOUNCE > 255) begin : g_bad_debounce
    $error("DEBOUNCE out of range 1..255");
  end
  if (STUCK_LIMIT < 1 || STUCK_LIMIT > 65535) begin : g_bad_stuck_limit
    $error("STUCK_LIMIT out of range 1..65535");
  end

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);

  // Bits 3:0 are the car loops, bit 4 is the pedestrian button.
  logic [4:0] sync1;
  logic [4:0] s;
  logic [4:0] d;
  logic [7:0] db_cnt [5];
  logic       d_btn_q;
  logic       ped_q;
  logic [3:0] stuck_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      s     <= '0;
      d     <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {bus.raw_button, bus.raw_car};
      s     <= sync1;
      for (int i = 0; i < 5; i++) begin
        if (s[i] == d[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          d[i]      <= s[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Set is edge-triggered on the debounced button and wins over a same-cycle clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_btn_q <= 1'b0;
      ped_q   <= 1'b0;
    end else begin
      d_btn_q <= d[4];
      if (d[4] && !d_btn_q) begin
        ped_q <= 1'b1;
      end else if (bus.ped_clr) begin
        ped_q <= 1'b0;
      end
    end
  end

`ifdef TRAFFIC_STUCK_DET_EN
  localparam logic [15:0] STUCK_LAST = 16'(STUCK_LIMIT - 1);

  logic [15:0] stuck_cnt [4];

  // Counting halts once flagged, so the counter cannot wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stuck_q <= '0;
      for (int i = 0; i < 4; i++) stuck_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!d[i]) begin
          stuck_cnt[i] <= '0;
          stuck_q[i]   <= 1'b0;
        end else if (!stuck_q[i]) begin
          stuck_cnt[i] <= stuck_cnt[i] + 16'd1;
          if (stuck_cnt[i] == STUCK_LAST) stuck_q[i] <= 1'b1;
        end
      end
    end
  end
`else
  assign stuck_q = 4'b0000;
`endif

  assign bus.car1  = d[0] & ~stuck_q[0];
  assign bus.car2  = d[1] & ~stuck_q[1];
  assign bus.car3  = d[2] & ~stuck_q[2];
  assign bus.car4  = d[3] & ~stuck_q[3];
  assign bus.ped   = ped_q;
  assign bus.stuck = stuck_q;

endmodule
